// File: rtl/shift_reg_pkg.sv
// Shared mode, state and direction codes for the universal shift register.
// Imported by the burst controller, the top datapath and the bench.
package shift_reg_pkg;

  typedef enum logic [1:0] {
    HOLD      = 2'b00,
    SHIFT     = 2'b01,
    PARA_LOAD = 2'b10,
    ROTATE    = 2'b11
  } mode_e;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam logic LEFT  = 1'b0;
  localparam logic RIGHT = 1'b1;

  function automatic logic is_burst_mode(input logic [1:0] m);
    return (m == SHIFT) || (m == ROTATE);
  endfunction

endpackage

// File: rtl/shift_reg_universal_n_if.sv
// Control/data bundle of the universal shift register.
// The master drives controls and data; the slave is the register.
interface shift_reg_universal_n_if #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
);
  logic             ENB;
  logic [1:0]       MODO;
  logic             DIR;
  logic             S_IN;
  logic [WIDTH-1:0] D;
  logic             START;
  logic [CNT_W-1:0] COUNT;
  logic [WIDTH-1:0] Q;
  logic             S_OUT;
  logic             BUSY;
  logic             DONE;

  modport master (
    output ENB, MODO, DIR, S_IN, D, START, COUNT,
    input  Q, S_OUT, BUSY, DONE
  );

  modport slave (
    input  ENB, MODO, DIR, S_IN, D, START, COUNT,
    output Q, S_OUT, BUSY, DONE
  );
endinterface

// File: rtl/shift_burst_ctrl.sv
// Burst FSM: latches count/mode/dir, issues one step per enabled edge,
// and produces BUSY plus a registered one-cycle DONE.
module shift_burst_ctrl
  import shift_reg_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enb,
  input  logic [1:0]       modo,
  input  logic             dir,
  input  logic             start,
  input  logic [CNT_W-1:0] count,
  output logic             step,
  output mode_e            eff_mode,
  output logic             eff_dir,
  output logic             busy,
  output logic             done
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  mode_e            mode_q, mode_d;
  logic             dir_q, dir_d;
  logic             done_q, done_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      mode_q  <= HOLD;
      dir_q   <= LEFT;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      dir_q   <= dir_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mode_d   = mode_q;
    dir_d    = dir_q;
    done_d   = 1'b0;
    step     = 1'b0;
    eff_mode = mode_e'(modo);
    eff_dir  = dir;
    unique case (state_q)
      IDLE: begin
        step = enb;
        if (enb && start && is_burst_mode(modo)) begin
          // Accepting a burst consumes the edge without shifting.
          step = 1'b0;
          if (count != '0) begin
            state_d = RUN;
            cnt_d   = count;
            mode_d  = mode_e'(modo);
            dir_d   = dir;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      RUN: begin
        eff_mode = mode_q;
        eff_dir  = dir_q;
        if (enb) begin
          step  = 1'b1;
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q == RUN);
  assign done = done_q;

endmodule

// File: rtl/shift_reg_universal_n.sv
// Parametrised universal shift register with hold/shift/load/rotate
// and a counted shift/rotate burst engine.
module shift_reg_universal_n
  import shift_reg_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input logic                    CLK,
  input logic                    RESET_N,
  shift_reg_universal_n_if.slave bus
);

  logic             step;
  mode_e            eff_mode;
  logic             eff_dir;
  logic [WIDTH-1:0] q_q, q_d;

  shift_burst_ctrl #(
    .CNT_W(CNT_W)
  ) u_ctrl (
    .clk     (CLK),
    .rst_n   (RESET_N),
    .enb     (bus.ENB),
    .modo    (bus.MODO),
    .dir     (bus.DIR),
    .start   (bus.START),
    .count   (bus.COUNT),
    .step    (step),
    .eff_mode(eff_mode),
    .eff_dir (eff_dir),
    .busy    (bus.BUSY),
    .done    (bus.DONE)
  );

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) q_q <= '0;
    else          q_q <= q_d;
  end

  always_comb begin
    q_d = q_q;
    if (step) begin
      unique case (eff_mode)
        HOLD:      q_d = q_q;
        SHIFT:     q_d = (eff_dir == LEFT)
                         ? {q_q[WIDTH-2:0], bus.S_IN}
                         : {bus.S_IN, q_q[WIDTH-1:1]};
        PARA_LOAD: q_d = bus.D;
        ROTATE:    q_d = (eff_dir == LEFT)
                         ? {q_q[WIDTH-2:0], q_q[WIDTH-1]}
                         : {q_q[0], q_q[WIDTH-1:1]};
        default:   q_d = q_q;
      endcase
    end
  end

  assign bus.Q     = q_q;
  assign bus.S_OUT = (eff_dir == LEFT) ? q_q[WIDTH-1] : q_q[0];

endmodule

// File: tb/tb_shift_reg_universal_n.sv
// Directed bench for shift_reg_universal_n at WIDTH=8.
// Inputs change on the falling edge; outputs are checked there too.
module tb_shift_reg_universal_n;
  import shift_reg_pkg::*;

  localparam int W  = 8;
  localparam int CW = 8;

  logic CLK = 1'b0;
  logic RESET_N = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 CLK = ~CLK;

  shift_reg_universal_n_if #(.WIDTH(W), .CNT_W(CW)) bus ();

  shift_reg_universal_n #(.WIDTH(W), .CNT_W(CW)) dut (
    .CLK    (CLK),
    .RESET_N(RESET_N),
    .bus    (bus.slave)
  );

  task automatic nedge();
    @(negedge CLK);
    #1;
  endtask

  task automatic load(input logic [W-1:0] v);
    bus.MODO  = PARA_LOAD;
    bus.D     = v;
    bus.START = 1'b0;
    nedge();
    bus.MODO  = HOLD;
  endtask

  task automatic test_reset();
    bus.ENB = 1'b1; bus.MODO = HOLD; bus.DIR = LEFT;
    bus.S_IN = 1'b0; bus.D = '0; bus.START = 1'b0; bus.COUNT = '0;
    RESET_N = 1'b0;
    nedge();
    n_vec++;
    if (bus.Q !== 8'h00 || bus.BUSY !== 1'b0 || bus.DONE !== 1'b0) begin
      n_err++;
      $display("FAIL reset q=%h busy=%b done=%b exp 00/0/0",
               bus.Q, bus.BUSY, bus.DONE);
    end
    RESET_N = 1'b1;
    nedge();
  endtask

  task automatic test_load_shift();
    load(8'hA5);
    n_vec++;
    if (bus.Q !== 8'hA5) begin
      n_err++; $display("FAIL load q=%h exp=a5", bus.Q);
    end
    bus.MODO = SHIFT; bus.DIR = LEFT; bus.S_IN = 1'b1;
    #1;
    n_vec++;
    if (bus.S_OUT !== 1'b1) begin
      n_err++; $display("FAIL sout_pre got=%b exp=1", bus.S_OUT);
    end
    nedge();
    n_vec++;
    if (bus.Q !== 8'h4B || bus.S_OUT !== 1'b0) begin
      n_err++;
      $display("FAIL shift q=%h sout=%b exp 4b/0", bus.Q, bus.S_OUT);
    end
    bus.MODO = HOLD;
  endtask

  task automatic test_rotate_burst();
    logic [W-1:0] exp_q [3];
    exp_q[0] = 8'hC0; exp_q[1] = 8'h60; exp_q[2] = 8'h30;
    load(8'h81);
    bus.MODO = ROTATE; bus.DIR = RIGHT;
    bus.START = 1'b1; bus.COUNT = 8'd3;
    nedge();
    bus.START = 1'b0; bus.MODO = HOLD;
    n_vec++;
    if (bus.Q !== 8'h81 || bus.BUSY !== 1'b1 || bus.DONE !== 1'b0) begin
      n_err++;
      $display("FAIL rot_accept q=%h busy=%b done=%b exp 81/1/0",
               bus.Q, bus.BUSY, bus.DONE);
    end
    for (int i = 0; i < 3; i++) begin
      nedge();
      n_vec++;
      if (bus.Q !== exp_q[i] || bus.BUSY !== (i < 2) ||
          bus.DONE !== (i == 2)) begin
        n_err++;
        $display("FAIL rot_step%0d q=%h busy=%b done=%b exp %h/%b/%b",
                 i, bus.Q, bus.BUSY, bus.DONE, exp_q[i], i < 2, i == 2);
      end
    end
    nedge();
    n_vec++;
    if (bus.DONE !== 1'b0 || bus.Q !== 8'h30) begin
      n_err++;
      $display("FAIL rot_after q=%h done=%b exp 30/0", bus.Q, bus.DONE);
    end
  endtask

  task automatic test_pause();
    int busy_n;
    logic [W-1:0] exp_q [6];
    logic         enb_v [6];
    exp_q[0] = 8'h02; enb_v[0] = 1'b1;
    exp_q[1] = 8'h04; enb_v[1] = 1'b1;
    exp_q[2] = 8'h04; enb_v[2] = 1'b0;
    exp_q[3] = 8'h04; enb_v[3] = 1'b0;
    exp_q[4] = 8'h08; enb_v[4] = 1'b1;
    exp_q[5] = 8'h11; enb_v[5] = 1'b1;
    load(8'h01);
    bus.MODO = SHIFT; bus.DIR = LEFT; bus.S_IN = 1'b0;
    bus.START = 1'b1; bus.COUNT = 8'd4;
    nedge();
    bus.START = 1'b0; bus.MODO = HOLD;
    busy_n = bus.BUSY ? 1 : 0;
    for (int i = 0; i < 6; i++) begin
      bus.ENB  = enb_v[i];
      bus.S_IN = (i == 5);
      nedge();
      if (bus.BUSY) busy_n++;
      n_vec++;
      if (bus.Q !== exp_q[i] || bus.DONE !== (i == 5)) begin
        n_err++;
        $display("FAIL pause_%0d q=%h done=%b exp %h/%b",
                 i, bus.Q, bus.DONE, exp_q[i], i == 5);
      end
    end
    bus.ENB = 1'b1; bus.S_IN = 1'b0;
    n_vec++;
    if (busy_n != 6) begin
      n_err++; $display("FAIL pause_busy cycles=%0d exp=6", busy_n);
    end
  endtask

  task automatic test_zero_count();
    bus.MODO = SHIFT; bus.DIR = LEFT; bus.S_IN = 1'b1;
    bus.START = 1'b1; bus.COUNT = 8'd0;
    nedge();
    bus.START = 1'b0; bus.MODO = HOLD;
    n_vec++;
    if (bus.Q !== 8'h11 || bus.BUSY !== 1'b0 || bus.DONE !== 1'b1) begin
      n_err++;
      $display("FAIL zero q=%h busy=%b done=%b exp 11/0/1",
               bus.Q, bus.BUSY, bus.DONE);
    end
    nedge();
    n_vec++;
    if (bus.DONE !== 1'b0 || bus.Q !== 8'h11) begin
      n_err++;
      $display("FAIL zero_after q=%h done=%b exp 11/0", bus.Q, bus.DONE);
    end
  endtask

  task automatic test_reset_mid();
    int done_n;
    load(8'h0F);
    bus.MODO = SHIFT; bus.DIR = LEFT; bus.S_IN = 1'b0;
    bus.START = 1'b1; bus.COUNT = 8'd5;
    nedge();
    bus.START = 1'b0; bus.MODO = HOLD;
    nedge();
    nedge();
    n_vec++;
    if (bus.Q !== 8'h3C || bus.BUSY !== 1'b1) begin
      n_err++;
      $display("FAIL rmid_pre q=%h busy=%b exp 3c/1", bus.Q, bus.BUSY);
    end
    #1 RESET_N = 1'b0;
    #1;
    n_vec++;
    if (bus.Q !== 8'h00 || bus.BUSY !== 1'b0 || bus.DONE !== 1'b0) begin
      n_err++;
      $display("FAIL rmid_async q=%h busy=%b done=%b exp 00/0/0",
               bus.Q, bus.BUSY, bus.DONE);
    end
    nedge();
    RESET_N = 1'b1;
    done_n = 0;
    for (int i = 0; i < 6; i++) begin
      nedge();
      if (bus.DONE) done_n++;
    end
    n_vec++;
    if (done_n != 0 || bus.BUSY !== 1'b0) begin
      n_err++;
      $display("FAIL rmid_nodone dones=%0d busy=%b exp 0/0",
               done_n, bus.BUSY);
    end
  endtask

  task automatic test_ignored();
    load(8'hC1);
    bus.MODO = SHIFT; bus.DIR = LEFT; bus.S_IN = 1'b0;
    bus.START = 1'b1; bus.COUNT = 8'd2;
    nedge();
    bus.START = 1'b0;
    bus.MODO = PARA_LOAD; bus.D = 8'hFF; bus.DIR = RIGHT;
    nedge();
    n_vec++;
    if (bus.Q !== 8'h82 || bus.S_OUT !== 1'b1) begin
      n_err++;
      $display("FAIL ign_1 q=%h sout=%b exp 82/1", bus.Q, bus.S_OUT);
    end
    nedge();
    bus.MODO = HOLD;
    n_vec++;
    if (bus.Q !== 8'h04 || bus.DONE !== 1'b1) begin
      n_err++;
      $display("FAIL ign_2 q=%h done=%b exp 04/1", bus.Q, bus.DONE);
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] exp_q [4];
    logic         exp_b [4];
    logic         exp_d [4];
    exp_q[0] = 8'h04; exp_b[0] = 1'b1; exp_d[0] = 1'b0;
    exp_q[1] = 8'h08; exp_b[1] = 1'b0; exp_d[1] = 1'b1;
    exp_q[2] = 8'h08; exp_b[2] = 1'b1; exp_d[2] = 1'b0;
    exp_q[3] = 8'h10; exp_b[3] = 1'b0; exp_d[3] = 1'b1;
    bus.MODO = ROTATE; bus.DIR = LEFT;
    bus.START = 1'b1; bus.COUNT = 8'd1;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) begin
        bus.START = 1'b0; bus.MODO = HOLD;
      end
      nedge();
      n_vec++;
      if (bus.Q !== exp_q[i] || bus.BUSY !== exp_b[i] ||
          bus.DONE !== exp_d[i]) begin
        n_err++;
        $display("FAIL b2b_%0d q=%h busy=%b done=%b exp %h/%b/%b",
                 i, bus.Q, bus.BUSY, bus.DONE,
                 exp_q[i], exp_b[i], exp_d[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_load_shift();
    test_rotate_burst();
    test_pause();
    test_zero_count();
    test_reset_mid();
    test_ignored();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
